// File: rtl/bias_ram_writer_if.sv
// rtl/bias_ram_writer_if.sv - bias word stream and bias RAM write port bundle
//
// Groups the two buses of bias_ram_writer:
//   in_valid/in_data/in_ready : incoming bias word stream (valid/ready handshake)
//   wr_en/wr_addr/wr_data     : bias RAM write port
// Modports:
//   master : the writer (consumes the stream, drives the RAM port)
//   slave  : the peer side (drives the stream, observes the RAM port)

`ifndef N_LEN
`define N_LEN 16
`endif

interface bias_ram_writer_if #(
  parameter int DATA_W = `N_LEN,
  parameter int ADDR_W = `N_LEN
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/bias_ram_writer.sv
// rtl/bias_ram_writer.sv - loads one layer of bias words into the mix-layer bias RAM
//
// Accepts DEPTH bias words over a valid/ready stream and writes them to the bias
// RAM at base 0, DEPTH or 2*DEPTH chosen by the MIX1/MIX2/MIX3 state code.
// Optional feature macro: BIAS_WR_CHECKSUM_EN (running sum of written words).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle load request, state sampled with it
//   state      : layer select code
//   bus        : bias_ram_writer_if.master (stream in, RAM write port out)
//   busy       : load in progress
//   done       : pulse alongside the final word's write
//   err        : pulse the cycle after a start with an unsupported code
//   checksum   : running sum of written words (0 when the feature is off)

`ifndef HID_DIM
`define HID_DIM 64
`endif
`ifndef N_LEN
`define N_LEN 16
`endif
`ifndef STATE_LEN
`define STATE_LEN 3
`endif
`ifndef MIX1
`define MIX1 3'd1
`endif
`ifndef MIX2
`define MIX2 3'd2
`endif
`ifndef MIX3
`define MIX3 3'd3
`endif

module bias_ram_writer #(
  parameter int DEPTH  = `HID_DIM,
  parameter int DATA_W = `N_LEN,
  parameter int ADDR_W = `N_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [`STATE_LEN-1:0] state,
  bias_ram_writer_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_W-1:0]     checksum
);

  localparam logic [ADDR_W-1:0] BASE_1 = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_2 = ADDR_W'(2 * DEPTH);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, LOAD} fsm_t;

  fsm_t              fsm, fsm_next;
  logic [ADDR_W-1:0] base, base_sel, cnt;
  logic              accept, start_ok, start_bad, last_word;

  assign last_word    = (cnt == LAST);
  assign bus.in_ready = (fsm == LOAD);
  assign busy         = (fsm == LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_next;
  end

  always_comb begin
    fsm_next  = fsm;
    accept    = 1'b0;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    base_sel  = '0;
    case (fsm)
      IDLE: begin
        if (start) begin
          case (state)
            `MIX1: begin start_ok = 1'b1; base_sel = '0;     fsm_next = LOAD; end
            `MIX2: begin start_ok = 1'b1; base_sel = BASE_1; fsm_next = LOAD; end
            `MIX3: begin start_ok = 1'b1; base_sel = BASE_2; fsm_next = LOAD; end
            default: start_bad = 1'b1;
          endcase
        end
      end
      LOAD: begin
        // start is deliberately not examined here: requests during a load are dropped
        if (bus.in_valid) begin
          accept = 1'b1;
          if (last_word) fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base        <= '0;
      cnt         <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      bus.wr_en <= accept;
      done      <= accept && last_word;
      err       <= start_bad;
      if (start_ok) begin
        base <= base_sel;
        cnt  <= '0;
      end
      // address/data hold their last values between writes
      if (accept) begin
        bus.wr_addr <= base + cnt;
        bus.wr_data <= bus.in_data;
        cnt         <= cnt + 1'b1;
      end
    end
  end

`ifdef BIAS_WR_CHECKSUM_EN
  // Summed at accept time so the total lands together with the matching wr_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (accept)   checksum <= checksum + bus.in_data;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_bias_ram_writer.sv
// tb/tb_bias_ram_writer.sv - scoreboard testbench for bias_ram_writer

`ifndef STATE_LEN
`define STATE_LEN 3
`endif
`ifndef MIX1
`define MIX1 3'd1
`endif
`ifndef MIX2
`define MIX2 3'd2
`endif
`ifndef MIX3
`define MIX3 3'd3
`endif

module tb_bias_ram_writer;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
    logic [DATA_W-1:0] csum;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [`STATE_LEN-1:0] state = '0;
  logic                  busy, done, err;
  logic [DATA_W-1:0]     checksum;

  bias_ram_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  bias_ram_writer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .state(state), .bus(bus),
    .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  wr_t q[$];
  logic [DATA_W-1:0] exp_sum = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.wr_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        wr_t e;
        e = q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        check("wr_data", 32'(bus.wr_data), 32'(e.data));
        check("done", 32'(done), 32'(e.last));
        if (e.last) begin
          check("checksum_at_done", 32'(checksum), 32'(e.csum));
          check("busy_at_done", 32'(busy), 32'd0);
          check("in_ready_at_done", 32'(bus.in_ready), 32'd0);
        end
      end
    end else if (rst_n && done) begin
      checks++;
      errors++;
      $display("FAIL done_without_write: got done 1 expected 0");
    end
  end

  task automatic do_start(input logic [`STATE_LEN-1:0] code, input logic valid_code);
    start = 1'b1;
    state = code;
    @(posedge clk);
    #1;
    start = 1'b0;
    state = 3'd7;
    if (valid_code) exp_sum = '0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a, input logic last);
    wr_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    exp_sum      = exp_sum + d;
    e.addr = a;
    e.data = d;
    e.last = last;
`ifdef BIAS_WR_CHECKSUM_EN
    e.csum = exp_sum;
`else
    e.csum = '0;
`endif
    q.push_back(e);
    check("in_ready_loading", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
    check({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
    check({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_done"},     32'(done),         32'd0);
    check({tag, "_err"},      32'(err),          32'd0);
    check({tag, "_checksum"}, 32'(checksum),     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset hold and release
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    idle(2);
    check_reset_outputs("after_reset");

    // MIX2, back-to-back words -> addrs 4..7, checksum 0xAA
    do_start(`MIX2, 1'b1);
    check("busy_in_load", 32'(busy), 32'd1);
    send(8'h11, 8'd4, 1'b0);
    send(8'h22, 8'd5, 1'b0);
    send(8'h33, 8'd6, 1'b0);
    send(8'h44, 8'd7, 1'b1);
    idle(2);

    // MIX3 with a 3-cycle stall and a start during LOAD that must be ignored
    do_start(`MIX3, 1'b1);
    send(8'h55, 8'd8, 1'b0);
    send(8'h66, 8'd9, 1'b0);
    idle(3);
    start = 1'b1;
    state = `MIX1;
    send(8'h77, 8'd10, 1'b0);
    start = 1'b0;
    send(8'h88, 8'd11, 1'b1);
    idle(2);

    // Unsupported state code
    do_start(3'd0, 1'b0);
    check("err_pulse", 32'(err), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    check("err_in_ready", 32'(bus.in_ready), 32'd0);
    idle(1);
    check("err_single", 32'(err), 32'd0);
    check("err_still_idle", 32'(busy), 32'd0);
    idle(1);

    // MIX1 aborted by reset after two words
    do_start(`MIX1, 1'b1);
    send(8'h01, 8'd0, 1'b0);
    send(8'h02, 8'd1, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    check_reset_outputs("abort_release");

    // Full MIX1 load, then start right after the final accept
    do_start(`MIX1, 1'b1);
    send(8'hA1, 8'd0, 1'b0);
    send(8'hA2, 8'd1, 1'b0);
    send(8'hA3, 8'd2, 1'b0);
    send(8'hA4, 8'd3, 1'b1);
    check("ready_after_final", 32'(bus.in_ready), 32'd0);
    do_start(`MIX3, 1'b1);
    check("ready_two_after_final", 32'(bus.in_ready), 32'd1);
    send(8'hB1, 8'd8, 1'b0);
    send(8'hB2, 8'd9, 1'b0);
    send(8'hB3, 8'd10, 1'b0);
    send(8'hB4, 8'd11, 1'b1);
    idle(3);

    check("pending_writes", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
